rv32i_inst_encoder: RTL and testbench
=====================================

Name: rv32i_inst_encoder

Overview:
- Streaming RV32I instruction encoder; inverse of the core's decode path.
- Takes decoded fields (optype, opcode, rd, rs1, rs2, funct3, funct7, signed immediate) and packs them into a 32-bit instruction word.
- Tags each word with a sequential word address, ready for an instruction-RAM writer or boot/self-test program builder.
- Valid/ready on both sides with a 2-entry output buffer; range errors are flagged per word, not dropped.

Parameters:
ADDR_W, 12, width of the output word-address counter (wraps modulo 2^ADDR_W)

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: flush buffer, load address counter, clear sticky error
start_addr  in  ADDR_W  word address loaded on start
in_valid  in  1  field set valid
in_ready  out  1  encoder can accept this cycle
in_optype  in  3  optype_e (RTYPE..JTYPE)
in_opcode  in  7  opcode_e value, passed verbatim
in_rd, in_rs1, in_rs2  in  5 each  register indices
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R-type; I-type shift-immediate upper bits)
in_imm  in  32  signed byte-offset / immediate value
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts
out_inst  out  32  encoded instruction
out_addr  out  ADDR_W  word address assigned to out_inst
out_err  out  1  this word had an out-of-range or misaligned immediate
err_sticky  out  1  any out_err since reset/start
word_count  out  ADDR_W+1  words handed off (out_valid&&out_ready) since reset/start

Behaviour:
- Reset values:
  - out_valid=0, in_ready=1, out_inst=0, out_addr=0, out_err=0, err_sticky=0, word_count=0.
  - Address counter=0; buffer empty.
- Accept on in_valid&&in_ready.
  - Encoding is combinational from the inputs and is registered into the buffer on acceptance.
  - Word is on out_* the next cycle; latency 1.
- Accepted word takes the current address counter value; counter then increments, wrapping 2^ADDR_W-1 -> 0.
- Buffer: 2-entry FIFO.
  - in_ready = !full && !start, a registered full flag, no combinational path from out_ready.
  - Sustains 1 word/cycle when out_ready=1.
  - Simultaneous push and pop when full is not allowed (in_ready=0); push and pop at occupancy 1 holds occupancy.
  - Output order is strictly input order.
- Encoding per in_optype (bits MSB..LSB):
  - RTYPE: funct7|rs2|rs1|funct3|rd|opcode; never errs.
  - ITYPE: imm[11:0]|rs1|funct3|rd|opcode; err if imm not in [-2048,2047].
  - ITYPE shift-immediate (opcode OP_OPIMM and funct3 in {001,101}): field = funct7|imm[4:0]; err if imm not in [0,31].
  - STYPE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode; err if imm not in [-2048,2047].
  - BTYPE: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode; err if imm not in [-4096,4094] or imm[0]=1.
  - UTYPE: imm[31:12]|rd|opcode; err if imm[11:0]!=0.
  - JTYPE: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode; err if imm not in [-2^20,2^20-2] or imm[0]=1.
  - Undefined optype codes (6,7): out_inst=0, err=1.
- On err: the truncated encoding is still emitted; out_err=1 with that word; err_sticky sets at acceptance.
- start (highest priority):
  - Next cycle: buffer empty, out_valid=0, counter=start_addr, err_sticky=0, word_count=0.
  - Inputs offered in the start cycle are not accepted (in_ready=0).
  - A pending output handshake in the start cycle still counts toward nothing (word_count cleared).
- Reset asserted mid-stream: immediate return to reset values; buffered words are lost.

Decomposition:
- Shared package additions (alongside optype_e/opcode_e):
  - Immediate range constants (IMM12_MIN/MAX, IMMB_MIN/MAX, IMMJ_MIN/MAX).
  - Function rv32i_encode(optype, fields) returning {err, inst[31:0]}, so encoder and testbench golden model share one definition.
  - Packed struct inst_fields_s for the input bundle.
- One sub-module: rv32i_skid_fifo2, a 2-entry valid/ready buffer with a registered full flag, parameterized data width.

Test Plan:
- addi x1,x0,5 (ITYPE, op 0010011, f3 000, rd 1, rs1 0, imm 5), start_addr 0 -> out_inst 0x00500093, out_addr 0, out_err 0, one cycle after accept.
- Back-to-back, out_ready=1:
  - sw x2,8(x1) -> 0x0020A423 @addr 1.
  - beq x0,x0,-4 -> 0xFE000EE3 @addr 2.
  - jal x1,2048 -> 0x001000EF @addr 3.
  - lui x5,0x12345000 -> 0x123452B7 @addr 4.
  - Expect 1 word/cycle; word_count=5.
- Errors:
  - beq imm=3 -> out_err=1, err_sticky=1.
  - addi imm=2048 -> out_err=1.
  - slli imm=32 -> out_err=1.
  - Following valid words have out_err=0 and err_sticky stays 1.
- Continuous in_valid with out_ready=0 for 4 cycles -> exactly 2 words accepted, then in_ready=0. Releasing out_ready drains in order with consecutive addresses and nothing lost or duplicated.
- ADDR_W=12, start_addr=0xFFE, 3 words -> out_addr 0xFFE, 0xFFF, 0x000.
- start mid-stream with 2 buffered words and start_addr=0x100:
  - Next cycle out_valid=0, err_sticky=0, word_count=0.
  - Next accepted word gets out_addr 0x100.
  - Reset asserted asynchronously mid-transfer drops out_valid immediately.

Source files
------------

// File: rtl/rv32i_inst_encoder_pkg.sv
// rv32i_inst_encoder_pkg: RV32I field/opcode types, immediate ranges and the shared field-to-word packer.
package rv32i_inst_encoder_pkg;
  typedef enum logic [2:0] {RTYPE, ITYPE, STYPE, BTYPE, UTYPE, JTYPE} optype_e;
  typedef enum logic [6:0] {
    OP_LOAD = 7'b0000011, OP_OPIMM = 7'b0010011, OP_AUIPC = 7'b0010111, OP_STORE = 7'b0100011,
    OP_OP = 7'b0110011, OP_LUI = 7'b0110111, OP_BRANCH = 7'b1100011, OP_JALR = 7'b1100111,
    OP_JAL = 7'b1101111, OP_SYSTEM = 7'b1110011
  } opcode_e;
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN = -4096;
  localparam int IMMB_MAX = 4094;
  localparam int IMMJ_MIN = -(1 << 20);
  localparam int IMMJ_MAX = (1 << 20) - 2;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [31:0] imm;
  } inst_fields_s;
  // Returns {err, inst}; out-of-range immediates still produce the truncated encoding.
  function automatic logic [32:0] rv32i_encode(input logic [2:0] optype, input inst_fields_s f);
    int s;
    logic shamt;
    s = $signed(f.imm);
    shamt = f.opcode == OP_OPIMM && f.funct3[1:0] == 2'b01;
    case (optype)
      RTYPE: return {1'b0, f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      ITYPE: return shamt ? {|f.imm[31:5], f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode}
                          : {s < IMM12_MIN || s > IMM12_MAX, f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      STYPE: return {s < IMM12_MIN || s > IMM12_MAX, f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      BTYPE: return {s < IMMB_MIN || s > IMMB_MAX || f.imm[0], f.imm[12], f.imm[10:5], f.rs2, f.rs1,
                     f.funct3, f.imm[4:1], f.imm[11], f.opcode};
      UTYPE: return {|f.imm[11:0], f.imm[31:12], f.rd, f.opcode};
      JTYPE: return {s < IMMJ_MIN || s > IMMJ_MAX || f.imm[0], f.imm[20], f.imm[10:1], f.imm[11],
                     f.imm[19:12], f.rd, f.opcode};
      default: return {1'b1, 32'h0};
    endcase
  endfunction
endpackage

// File: rtl/rv32i_skid_fifo2.sv
// rv32i_skid_fifo2: 2-entry valid/ready buffer, in_ready derived only from registered occupancy.
module rv32i_skid_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [1:0] cnt;
  logic [W-1:0] d1;
  logic push, pop;
  assign in_ready = !cnt[1] && !flush;
  assign push = in_valid && in_ready;
  assign out_valid = |cnt;
  assign pop = out_valid && out_ready;
  // out_data is the head slot; d1 holds the second entry when full.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      out_data <= '0;
      d1 <= '0;
    end else begin
      cnt <= flush ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
      if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) out_data <= in_data;
      else if (pop && cnt[1]) out_data <= d1;
      if (push && cnt == 2'd1 && !pop) d1 <= in_data;
    end
endmodule

// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder: packs decoded RV32I fields into address-tagged instruction words.
module rv32i_inst_encoder
  import rv32i_inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_optype,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic [ADDR_W:0]   word_count
);
  inst_fields_s f;
  logic [32:0] enc;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W+32:0] head;
  logic push, pop;
  assign f = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2, funct3: in_funct3,
               funct7: in_funct7, imm: in_imm};
  assign enc = rv32i_encode(in_optype, f);
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign {out_err, out_inst, out_addr} = head;
  rv32i_skid_fifo2 #(.W(ADDR_W + 33)) u_fifo (
    .clk(clk), .reset(reset), .flush(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data({enc, addr}), .out_valid(out_valid), .out_ready(out_ready), .out_data(head)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr <= '0;
      err_sticky <= 1'b0;
      word_count <= '0;
    end else if (start) begin
      addr <= start_addr;
      err_sticky <= 1'b0;
      word_count <= '0;
    end else begin
      if (push) addr <= addr + 1'b1;
      if (push && enc[32]) err_sticky <= 1'b1;
      if (pop) word_count <= word_count + 1'b1;
    end
endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// tb_rv32i_inst_encoder: directed and random stimulus against an arithmetic scoreboard model.
module tb_rv32i_inst_encoder;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, out_ready = 1;
  logic [11:0] start_addr = '0;
  logic in_ready, out_valid, out_err, err_sticky;
  logic [2:0] in_optype = '0, in_funct3 = '0;
  logic [6:0] in_opcode = '0, in_funct7 = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0, out_inst;
  logic [11:0] out_addr;
  logic [12:0] word_count;

  rv32i_inst_encoder #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .in_valid(in_valid),
    .in_ready(in_ready), .in_optype(in_optype), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] inst; logic err; logic [11:0] addr;} exp_t;
  exp_t q[$];
  logic [11:0] m_addr = '0;
  logic [12:0] m_wc = '0;
  logic m_sticky = 0;
  int checks = 0, errors = 0, n_acc = 0;
  bit lit_en = 0;
  logic [31:0] lit_val = '0;
  int ops[8] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h37, 'h6F, 'h67};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Field placement computed with masks, shifts and integer range tests.
  function automatic logic [32:0] ref_enc(int ot, int op, int rd, int rs1, int rs2, int f3, int f7, int imm);
    longint r, li;
    bit e;
    li = imm;
    r = 0;
    e = 0;
    case (ot)
      0: r = op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | longint'(f7) << 25;
      1: if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
           r = op | rd << 7 | f3 << 12 | rs1 << 15 | (li & 31) << 20 | longint'(f7) << 25;
           e = imm < 0 || imm > 31;
         end else begin
           r = op | rd << 7 | f3 << 12 | rs1 << 15 | (li & 'hFFF) << 20;
           e = imm < -2048 || imm > 2047;
         end
      2: begin
           r = op | (li & 31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((li >> 5) & 127) << 25;
           e = imm < -2048 || imm > 2047;
         end
      3: begin
           r = op | ((li >> 11) & 1) << 7 | ((li >> 1) & 15) << 8 | f3 << 12 | rs1 << 15 | rs2 << 20
               | ((li >> 5) & 63) << 25 | ((li >> 12) & 1) << 31;
           e = imm < -4096 || imm > 4094 || (imm & 1) != 0;
         end
      4: begin
           r = op | rd << 7 | (li & 'hFFFFF000);
           e = (imm & 'hFFF) != 0;
         end
      5: begin
           r = op | rd << 7 | ((li >> 12) & 255) << 12 | ((li >> 11) & 1) << 20 | ((li >> 1) & 1023) << 21
               | ((li >> 20) & 1) << 31;
           e = imm < -(1 << 20) || imm > (1 << 20) - 2 || (imm & 1) != 0;
         end
      default: e = 1;
    endcase
    return {e, r[31:0]};
  endfunction

  task automatic drive(input int ot, op, rd, rs1, rs2, f3, f7, imm, input bit le = 0, input logic [31:0] lv = '0);
    in_valid = 1;
    in_optype = ot[2:0];
    in_opcode = op[6:0];
    in_rd = rd[4:0];
    in_rs1 = rs1[4:0];
    in_rs2 = rs2[4:0];
    in_funct3 = f3[2:0];
    in_funct7 = f7[6:0];
    in_imm = imm;
    lit_en = le;
    lit_val = lv;
  endtask

  task automatic idle();
    in_valid = 0;
    lit_en = 0;
  endtask

  task automatic clear_model(input logic [11:0] a);
    q.delete();
    m_addr = a;
    m_sticky = 0;
    m_wc = '0;
  endtask

  task automatic cycle();
    bit rdy, acc, popped;
    logic [32:0] e;
    @(negedge clk);
    rdy = q.size() < 2 && !start;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("err_sticky", err_sticky, m_sticky);
    chk("word_count", word_count, m_wc);
    if (q.size() != 0) begin
      chk("out_inst", out_inst, q[0].inst);
      chk("out_addr", out_addr, q[0].addr);
      chk("out_err", out_err, q[0].err);
    end
    acc = in_valid && rdy;
    popped = q.size() != 0 && out_ready;
    if (start) clear_model(start_addr);
    else begin
      if (popped) begin
        void'(q.pop_front());
        m_wc++;
      end
      if (acc) begin
        e = ref_enc(int'(in_optype), int'(in_opcode), int'(in_rd), int'(in_rs1), int'(in_rs2),
                    int'(in_funct3), int'(in_funct7), int'(in_imm));
        q.push_back('{inst: lit_en ? lit_val : e[31:0], err: e[32], addr: m_addr});
        m_sticky |= e[32];
        m_addr++;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_word_count", word_count, 0);
    reset = 0;
    clear_model('0);
    start = 1; start_addr = '0; cycle(); start = 0;
    drive(1, 'h13, 1, 0, 0, 0, 0, 5, 1, 32'h00500093); cycle();
    drive(2, 'h23, 0, 1, 2, 2, 0, 8, 1, 32'h0020A423); cycle();
    drive(3, 'h63, 0, 0, 0, 0, 0, -4, 1, 32'hFE000EE3); cycle();
    drive(5, 'h6F, 1, 0, 0, 0, 0, 2048, 1, 32'h001000EF); cycle();
    drive(4, 'h37, 5, 0, 0, 0, 0, 'h12345000, 1, 32'h123452B7); cycle();
    idle(); cycle(); cycle();
    chk("b2b_word_count", word_count, 5);
    drive(3, 'h63, 0, 1, 2, 0, 0, 3); cycle();
    drive(1, 'h13, 3, 4, 0, 0, 0, 2048); cycle();
    drive(1, 'h13, 3, 4, 0, 1, 0, 32); cycle();
    drive(1, 'h13, 2, 0, 0, 0, 0, -2048); cycle();
    drive(0, 'h33, 7, 8, 9, 0, 'h20, 0); cycle();
    idle(); repeat (3) cycle();
    chk("err_sticky_held", err_sticky, 1);
    out_ready = 0; n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 'h13, i + 10, 1, 0, 0, 0, i * 3);
      cycle();
    end
    chk("bp_accepted", n_acc, 2);
    chk("bp_in_ready", in_ready, 0);
    idle(); out_ready = 1; repeat (4) cycle();
    start = 1; start_addr = 12'hFFE; cycle(); start = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 'h33, i, i, i, 0, 0, 0);
      cycle();
    end
    idle(); repeat (3) cycle();
    chk("wrap_count", word_count, 3);
    out_ready = 0;
    drive(1, 'h13, 1, 1, 0, 0, 0, 1); cycle();
    drive(1, 'h13, 2, 1, 0, 0, 0, 2); cycle();
    idle(); start = 1; start_addr = 12'h100; cycle(); start = 0;
    cycle();
    chk("start_out_valid", out_valid, 0);
    out_ready = 1;
    drive(1, 'h13, 3, 1, 0, 0, 0, 3); cycle();
    idle();
    chk("start_first_addr", out_addr, 12'h100);
    cycle();
    for (int i = 0; i < 400; i++) begin
      int imm, mode, op, f3;
      mode = $urandom_range(0, 3);
      imm = mode == 0 ? int'($urandom_range(0, 80)) - 40 :
            mode == 1 ? (int'($urandom_range(0, 10000)) - 5000) & ~1 :
            mode == 2 ? int'($urandom) : int'($urandom_range(0, 1 << 22)) - (1 << 21);
      op = ops[$urandom_range(0, 7)];
      f3 = $urandom_range(0, 7);
      drive($urandom_range(0, 7), op, $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), f3, $urandom_range(0, 127), imm);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      start = $urandom_range(0, 49) == 0;
      start_addr = 12'($urandom);
      cycle();
    end
    start = 0; idle(); out_ready = 0;
    drive(0, 'h33, 1, 2, 3, 0, 0, 0); cycle();
    drive(0, 'h33, 4, 5, 6, 0, 0, 0); cycle();
    idle();
    #3 reset = 1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_word_count", word_count, 0);
    chk("async_in_ready", in_ready, 1);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    clear_model('0);
    out_ready = 1;
    drive(2, 'h23, 0, 3, 4, 2, 0, -2048); cycle();
    idle(); repeat (2) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
